// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 tables, inverse-cipher FSM state type and the
// byte-level transforms shared by the round logic and the top.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } aes_inv_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for a 4-bit round count; 0 outside 1..10.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (r == 4'(i)) v = RCON[i];
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant via repeated xtime.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [3:0] m
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte (r,c) sits at index r+4c, MSB first.
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb)
                       ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he)
                       ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9)
                       ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd)
                       ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round plus one step
// of the reversed key schedule.
//   i_st/i_rk : current state / round key
//   i_rcon    : round constant for the key step
//   i_last    : skip InvMixColumns (final round)
//   o_st/o_rk : next state / previous round key
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  input  logic         i_last,
  output logic [127:0] o_st,
  output logic [127:0] o_rk
);

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_add;

  assign {w_w0, w_w1, w_w2, w_w3} = i_rk;

  // Undo the forward schedule; w_n3 must exist before w_n0.
  assign w_n3 = w_w3 ^ w_w2;
  assign w_n2 = w_w2 ^ w_w1;
  assign w_n1 = w_w1 ^ w_w0;
  assign w_n0 = w_w0 ^ sub_word(rot_word(w_n3))
              ^ {i_rcon, 24'h000000};

  assign o_rk = {w_n0, w_n1, w_n2, w_n3};

  assign w_add = inv_sub_bytes(inv_shift_rows(i_st)) ^ o_rk;
  assign o_st  = i_last ? w_add : inv_mix_columns(w_add);

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryptor, one round per
// cycle, valid/ready on both sides.
//   in_valid/in_ready    : accept cipher_text + keyout (round-10 key)
//   out_valid/out_ready  : plaintext (and key) held until taken
//   key                  : recovered cipher key, only when
//                          AES_INV_KEY_OUT_EN is defined
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] keyout,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_INV_KEY_OUT_EN
  output logic [127:0] key,
`endif
  output logic [127:0] plaintext
);

  aes_inv_state_e r_state;
  aes_inv_state_e w_next;

  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [127:0] r_pt;
  logic [3:0]   r_rnd;
  logic         r_out_valid;

  logic         w_accept;
  logic         w_take;
  logic         w_last;
  logic         w_round;
  logic [7:0]   w_rcon;
  logic [127:0] w_st_nx;
  logic [127:0] w_rk_nx;

  assign in_ready = rst_n && (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_round  = (r_state == S_ROUND);
  assign w_take   = (r_state == S_DONE) && out_ready;
  assign w_last   = (r_rnd == 4'd1);
  assign w_rcon   = rcon_of(r_rnd);

  aes_inv_round u_round (
    .i_st   (r_st),
    .i_rk   (r_rk),
    .i_rcon (w_rcon),
    .i_last (w_last),
    .o_st   (w_st_nx),
    .o_rk   (w_rk_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_ROUND;
      S_ROUND: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Working state/key; the result registers are separate so
  // outputs read 0 everywhere except DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st        <= '0;
      r_rk        <= '0;
      r_rnd       <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_st  <= cipher_text ^ keyout;
      r_rk  <= keyout;
      r_rnd <= 4'd10;
    end else if (w_round) begin
      r_st  <= w_st_nx;
      r_rk  <= w_rk_nx;
      r_rnd <= r_rnd - 4'd1;
      if (w_last) begin
        r_pt        <= w_st_nx;
        r_out_valid <= 1'b1;
      end
    end else if (w_take) begin
      r_pt        <= '0;
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign plaintext = r_pt;

`ifdef AES_INV_KEY_OUT_EN
  logic [127:0] r_key;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_key <= '0;
    else if (w_round && w_last)
      r_key <= w_rk_nx;
    else if (w_take)
      r_key <= '0;
  end

  assign key = r_key;
`endif

endmodule
